// File: rtl/xf100_ifu_fetch_pkg.sv
// Shared constants, FSM encoding and J-immediate decode for the xf100 fetch unit.
package xf100_ifu_fetch_pkg;

  localparam int          XF100_PC_SIZE    = 32;
  localparam int          XF100_INSTR_SIZE = 32;
  localparam logic [31:0] IFU_RESET_PC     = 32'h8000_0000;
  localparam logic [6:0]  OPC_JAL          = 7'b1101111;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } ifu_state_e;

  // J-type immediate, sign-extended to the PC width.
  function automatic logic [XF100_PC_SIZE-1:0] jal_imm(input logic [XF100_INSTR_SIZE-1:0] instr);
    return {{(XF100_PC_SIZE-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/xf100_ifu_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide at any occupancy, including full.
module xf100_ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || pop_i);
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/xf100_ifu_fetch.sv
// xf100 instruction fetch: sequential PC generation, in-order bus requests, instruction buffer, redirect.
// Optional static JAL redirect on predecode is enabled by defining XF100_IFU_STATIC_JAL_EN.
module xf100_ifu_fetch
  import xf100_ifu_fetch_pkg::*;
#(
  parameter int                 PC_SIZE    = XF100_PC_SIZE,
  parameter int                 INSTR_SIZE = XF100_INSTR_SIZE,
  parameter logic [PC_SIZE-1:0] RESET_PC   = PC_SIZE'(IFU_RESET_PC),
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_o_req_valid,
  input  logic                  ifu_i_req_ready,
  output logic [PC_SIZE-1:0]    ifu_o_req_addr,
  input  logic                  ifu_i_rsp_valid,
  input  logic [INSTR_SIZE-1:0] ifu_i_rsp_instr,
  input  logic                  ifu_i_rsp_err,
  output logic                  ifu_o_rsp_ready,
  output logic                  ifu_o_instr_valid,
  input  logic                  ifu_i_instr_ready,
  output logic [INSTR_SIZE-1:0] ifu_o_instr,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic                  ifu_o_instr_err,
  input  logic                  exu_i_redirect_valid,
  input  logic [PC_SIZE-1:0]    exu_i_redirect_pc
);
  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam int              FW      = INSTR_SIZE + PC_SIZE + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

  ifu_state_e           state_q, state_d;
  logic [PC_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        outst_q, outst_d, drop_q, drop_d;
  logic [PC_SIZE-1:0]   pcq_q [FIFO_DEPTH];
  logic [AW-1:0]        pcq_wptr_q, pcq_rptr_q;
  logic                 req_hs, rsp_v, rsp_keep, any_redir, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [FW-1:0]        fifo_wdata, fifo_rdata;
  logic [PC_SIZE-1:0]   redir_pc;
  logic                 jal_fire;
  logic [PC_SIZE-1:0]   jal_pc;

  assign redir_pc        = exu_i_redirect_pc & ~PC_SIZE'(3);
  assign ifu_o_req_addr  = fetch_pc_q;
  assign ifu_o_rsp_ready = 1'b1;

`ifdef XF100_IFU_STATIC_JAL_EN
  logic               jal_vld_q;
  logic [PC_SIZE-1:0] jal_pc_q;
  logic               jal_hit;

  assign jal_hit = rsp_keep && !ifu_i_rsp_err && (ifu_i_rsp_instr[6:0] == OPC_JAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jal_vld_q <= 1'b0;
      jal_pc_q  <= '0;
    end else begin
      jal_vld_q <= jal_hit;
      jal_pc_q  <= pcq_q[pcq_rptr_q] + PC_SIZE'(jal_imm(ifu_i_rsp_instr));
    end
  end

  assign jal_fire = jal_vld_q;
  assign jal_pc   = jal_pc_q;
`else
  assign jal_fire = 1'b0;
  assign jal_pc   = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Buffer space is reserved at request time, so a response can always be pushed.
  always_comb begin
    any_redir       = exu_i_redirect_valid || jal_fire;
    ifu_o_req_valid = (state_q == ST_FETCH) && !any_redir && !fifo_full &&
                      (({1'b0, outst_q} + {1'b0, fifo_count}) < DEPTH_W);
    req_hs          = ifu_o_req_valid && ifu_i_req_ready;
    rsp_v           = ifu_i_rsp_valid && (outst_q != '0);
    rsp_keep        = rsp_v && (drop_q == '0) && !any_redir;
    outst_d         = outst_q + CW'(req_hs) - CW'(rsp_v);

    drop_d = drop_q;
    if (any_redir)                       drop_d = outst_d;
    else if (rsp_v && (drop_q != '0))    drop_d = drop_q - CW'(1);

    fetch_pc_d = fetch_pc_q;
    if (exu_i_redirect_valid) fetch_pc_d = redir_pc;
    else if (jal_fire)        fetch_pc_d = jal_pc;
    else if (req_hs)          fetch_pc_d = fetch_pc_q + PC_SIZE'(4);

    fifo_pop   = ifu_o_instr_valid && ifu_i_instr_ready && !exu_i_redirect_valid;
    fifo_wdata = {ifu_i_rsp_instr, pcq_q[pcq_rptr_q], ifu_i_rsp_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      pcq_wptr_q <= '0;
      pcq_rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) pcq_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if (req_hs) begin
        pcq_q[pcq_wptr_q] <= fetch_pc_q;
        pcq_wptr_q        <= pcq_wptr_q + AW'(1);
      end
      if (rsp_v) pcq_rptr_q <= pcq_rptr_q + AW'(1);
    end
  end

  xf100_ifu_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (exu_i_redirect_valid),
    .push_i  (rsp_keep),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ifu_o_instr_valid = !fifo_empty;
  assign {ifu_o_instr, ifu_o_pc, ifu_o_instr_err} = fifo_empty ? '0 : fifo_rdata;

endmodule
